// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch/decode sequencer driving an external program counter.
// Walks IDLE -> FETCH -> DECODE -> FETCH ..., parking in HALT on opcode 0xF.
// The program counter stays outside this block; it only receives load/inc strobes.
module pc_fetch_sequencer #(
  parameter int N  = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  pc_in,
  output logic [N-1:0]  pc_data,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          zero_flag,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [3:0] opcode;

  assign opcode = instr[IW-1:IW-4];

  // State register and instruction latch; ack is only honoured in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == OP_HALT) state <= S_HALT;
          else                   state <= S_FETCH;
        end
        S_HALT: begin
          if (start) state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and memory request decoded from state; an async reset clears them at once.
  always_comb begin
    pc_data     = '0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        busy      = 1'b1;
        imem_req  = 1'b1;
        imem_addr = pc_in;
      end
      S_DECODE: begin
        busy = 1'b1;
        case (opcode)
          OP_JMP: begin
            pc_load = 1'b1;
            pc_data = instr[N-1:0];
          end
          OP_BZ: begin
            if (zero_flag) begin
              pc_load = 1'b1;
              pc_data = instr[N-1:0];
            end else begin
              pc_inc = 1'b1;
            end
          end
          OP_HALT: begin
          end
          default: begin
            pc_inc      = 1'b1;
            instr_valid = 1'b1;
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        // resuming steps past the HALT word
        if (start) pc_inc = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a behavioural program counter
// (load wins over inc) and a scoreboard of expected DECODE results.
module tb_pc_fetch_sequencer;

  localparam int N  = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_data;
  logic          pc_load;
  logic          pc_inc;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          zero_flag = 1'b0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          busy;
  logic          halted;

  typedef struct packed {
    logic [15:0] ins;
    logic        ld;
    logic        inc;
    logic [7:0]  data;
    logic        iv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_fetch_sequencer #(.N(N), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc_in       (pc),
    .pc_data     (pc_data),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .zero_flag   (zero_flag),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // External program counter: load has priority over increment.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= 8'd0;
    else if (pc_load) pc <= pc_data;
    else if (pc_inc)  pc <= pc + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity and pc_data cleanliness, every cycle.
  always @(negedge clk) begin
    chk("excl_ld_inc", 32'(pc_load & pc_inc), 32'd0);
    if (!pc_load) chk("pc_data_idle", 32'(pc_data), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One instruction: wait for request, check address, ack after dly cycles, check DECODE.
  task automatic fetch_one(input logic [15:0] rd, input logic zf, input int dly,
                           input logic [7:0] exp_addr, input string tag);
    int          n;
    exp_t        e;
    exp_t        g;
    logic [7:0]  a;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".req"}, 32'(imem_req), 32'd1);
    chk({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
    a = imem_addr;
    e = '0;
    e.ins = rd;
    case (rd[15:12])
      4'h1: begin e.ld = 1'b1; e.data = rd[7:0]; end
      4'h2: begin
        if (zf) begin e.ld = 1'b1; e.data = rd[7:0]; end
        else e.inc = 1'b1;
      end
      4'hF: begin end
      default: begin e.inc = 1'b1; e.iv = 1'b1; end
    endcase
    sb.push_back(e);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, ".hold_req"}, 32'(imem_req), 32'd1);
      chk({tag, ".hold_addr"}, 32'(imem_addr), 32'(a));
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    zero_flag  = zf;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    #1;
    g = sb.pop_front();
    chk({tag, ".instr"}, 32'(instr), 32'(g.ins));
    chk({tag, ".pc_load"}, 32'(pc_load), 32'(g.ld));
    chk({tag, ".pc_inc"}, 32'(pc_inc), 32'(g.inc));
    chk({tag, ".pc_data"}, 32'(pc_data), 32'(g.data));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(g.iv));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".req_dec"}, 32'(imem_req), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.iv", 32'(instr_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.req", 32'(imem_req), 32'd0);

    pulse_start();
    fetch_one(16'h0012, 1'b0, 0, 8'h00, "nop0");
    fetch_one(16'h1031, 1'b0, 0, 8'h01, "jmp31");
    fetch_one(16'h2040, 1'b1, 0, 8'h31, "bz_taken");
    fetch_one(16'h2040, 1'b0, 0, 8'h40, "bz_not");
    fetch_one(16'h1005, 1'b0, 0, 8'h41, "jmp05");
    fetch_one(16'hF000, 1'b0, 0, 8'h05, "halt");

    // parked in HALT; a stray ack must be ignored
    for (int i = 0; i < 10; i++) begin
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.busy", 32'(busy), 32'd0);
      chk("halt.ld", 32'(pc_load), 32'd0);
      chk("halt.inc", 32'(pc_inc), 32'd0);
      chk("halt.req", 32'(imem_req), 32'd0);
      if (i == 5) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'h1077;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
      end
      tick();
    end
    imem_ack = 1'b0;
    chk("halt.instr_kept", 32'(instr), 32'h0000F000);
    start = 1'b1;
    #1;
    chk("resume.inc", 32'(pc_inc), 32'd1);
    chk("resume.ld", 32'(pc_load), 32'd0);
    tick();
    start = 1'b0;
    chk("resume.busy", 32'(busy), 32'd1);

    fetch_one(16'h0034, 1'b0, 3, 8'h06, "slow_ack");
    fetch_one(16'h10FF, 1'b0, 0, 8'h07, "jmpff");
    fetch_one(16'h0000, 1'b0, 0, 8'hFF, "nop_ff");
    fetch_one(16'h0055, 1'b0, 0, 8'h00, "wrap");

    // reset while a fetch is outstanding
    chk("mid.req", 32'(imem_req), 32'd1);
    chk("mid.addr", 32'(imem_addr), 32'h01);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst.req", 32'(imem_req), 32'd0);
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.addr", 32'(imem_addr), 32'd0);
    chk("mid_rst.instr", 32'(instr), 32'd0);
    tick();
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1099;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tick();
    chk("late_ack.busy", 32'(busy), 32'd0);
    chk("late_ack.instr", 32'(instr), 32'd0);
    chk("late_ack.req", 32'(imem_req), 32'd0);

    pulse_start();
    fetch_one(16'h0012, 1'b0, 0, 8'h00, "restart");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
